// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between the I-side and D-side miss paths.
// Define ARB_ROUND_ROBIN_EN to alternate winners on simultaneous requests (default: D over I).
module mem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    // state  | meaning
    // IDLE   | port free, grant on any request
    // ISSUE  | first strobe cycle for the latched winner
    // WAIT   | strobe held until memory drops busywait
    // DONE   | one-cycle release of the owner's busywait
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_writedata;
    logic [DATA_W-1:0] r_i_readdata;
    logic [DATA_W-1:0] r_d_readdata;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_grant;
    logic w_capture;

    assign w_i_req = I_READ;
    assign w_d_req = D_READ | D_WRITE;
    assign w_grant = (r_state == S_IDLE) & (w_i_req | w_d_req);
    assign w_capture = (r_state == S_WAIT) & ~MEM_BUSYWAIT & ~r_op_wr;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_last_owner <= OWN_I;
        end else if (r_state == S_DONE) begin
            r_last_owner <= r_owner;
        end
    end

    // On a tie the side that did not finish last takes the port.
    assign w_grant_d = w_d_req & (~w_i_req | (r_last_owner == OWN_I));
`else
    assign w_grant_d = w_d_req;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_i_req | w_d_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                MEM_READ    = ~r_op_wr;
                MEM_WRITE   = r_op_wr;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                MEM_READ  = ~r_op_wr;
                MEM_WRITE = r_op_wr;
                if (!MEM_BUSYWAIT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transaction context is captured once at grant and held until the next grant.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_owner         <= OWN_I;
            r_op_wr         <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
        end else if (w_grant) begin
            r_owner         <= w_grant_d ? OWN_D : OWN_I;
            r_op_wr         <= w_grant_d & D_WRITE;
            r_mem_address   <= w_grant_d ? D_ADDRESS : I_ADDRESS;
            r_mem_writedata <= D_WRITEDATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_i_readdata <= '0;
            r_d_readdata <= '0;
        end else if (w_capture) begin
            if (r_owner == OWN_D) begin
                r_d_readdata <= MEM_READDATA;
            end else begin
                r_i_readdata <= MEM_READDATA;
            end
        end
    end

    assign MEM_ADDRESS   = r_mem_address;
    assign MEM_WRITEDATA = r_mem_writedata;
    assign I_READDATA    = r_i_readdata;
    assign D_READDATA    = r_d_readdata;

    assign I_BUSYWAIT = w_i_req & ~((r_state == S_DONE) & (r_owner == OWN_I));
    assign D_BUSYWAIT = w_d_req & ~((r_state == S_DONE) & (r_owner == OWN_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        I_READ = 1'b0;
    logic [5:0]  I_ADDRESS = '0;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;
    logic        D_READ = 1'b0;
    logic        D_WRITE = 1'b0;
    logic [5:0]  D_ADDRESS = '0;
    logic [31:0] D_WRITEDATA = '0;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = '0;
    logic        MEM_BUSYWAIT = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        i_rd;
        logic [5:0]  i_a;
        logic        d_rd;
        logic        d_wr;
        logic [5:0]  d_a;
        logic [31:0] d_wd;
        logic        mb;
        logic [31:0] mrd;
        logic        e_mr;
        logic        e_mw;
        logic [5:0]  e_ma;
        logic [31:0] e_mwd;
        logic        e_ib;
        logic        e_db;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(
        input logic i_rd, input logic [5:0] i_a, input logic d_rd, input logic d_wr,
        input logic [5:0] d_a, input logic [31:0] d_wd, input logic mb, input logic [31:0] mrd,
        input logic e_mr, input logic e_mw, input logic [5:0] e_ma, input logic [31:0] e_mwd,
        input logic e_ib, input logic e_db, input logic [31:0] e_ird, input logic [31:0] e_drd);
        vec_t v;
        v.i_rd = i_rd; v.i_a = i_a; v.d_rd = d_rd; v.d_wr = d_wr; v.d_a = d_a; v.d_wd = d_wd;
        v.mb = mb; v.mrd = mrd; v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma; v.e_mwd = e_mwd;
        v.e_ib = e_ib; v.e_db = e_db; v.e_ird = e_ird; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [105:0] act;
        logic [105:0] exp;
        I_READ = v.i_rd; I_ADDRESS = v.i_a; D_READ = v.d_rd; D_WRITE = v.d_wr;
        D_ADDRESS = v.d_a; D_WRITEDATA = v.d_wd; MEM_BUSYWAIT = v.mb; MEM_READDATA = v.mrd;
        #1;
        act = {MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, I_BUSYWAIT, D_BUSYWAIT,
               I_READDATA, D_READDATA};
        exp = {v.e_mr, v.e_mw, v.e_ma, v.e_mwd, v.e_ib, v.e_db, v.e_ird, v.e_drd};
        check($sformatf("vec%0d", idx), {22'd0, act}, {22'd0, exp});
    endtask

    initial begin
        int cyc;
        int d_done;
        int i_done;

        // I read with 3 busy WAIT cycles; address change mid-transaction must be ignored
        vecs[0]  = mk(0,6'h00,0,0,6'h00,32'h0,       0,32'h0,        0,0,6'h00,32'h0,       0,0,32'h0,32'h0);
        vecs[1]  = mk(1,6'h05,0,0,6'h00,32'h0,       1,32'h0,        0,0,6'h00,32'h0,       1,0,32'h0,32'h0);
        vecs[2]  = mk(1,6'h05,0,0,6'h00,32'h0,       1,32'h0,        1,0,6'h05,32'h0,       1,0,32'h0,32'h0);
        vecs[3]  = mk(1,6'h3C,0,0,6'h00,32'h0,       1,32'h0,        1,0,6'h05,32'h0,       1,0,32'h0,32'h0);
        vecs[4]  = mk(1,6'h3C,0,0,6'h00,32'h0,       1,32'h0,        1,0,6'h05,32'h0,       1,0,32'h0,32'h0);
        vecs[5]  = mk(1,6'h3C,0,0,6'h00,32'h0,       1,32'h0,        1,0,6'h05,32'h0,       1,0,32'h0,32'h0);
        vecs[6]  = mk(1,6'h05,0,0,6'h00,32'h0,       0,32'hDEADBEEF, 1,0,6'h05,32'h0,       1,0,32'h0,32'h0);
        vecs[7]  = mk(1,6'h05,0,0,6'h00,32'h0,       0,32'h0,        0,0,6'h05,32'h0,       0,0,32'hDEADBEEF,32'h0);
        vecs[8]  = mk(0,6'h00,0,0,6'h00,32'h0,       0,32'h0,        0,0,6'h05,32'h0,       0,0,32'hDEADBEEF,32'h0);
        // D write, zero-wait memory; read data on the bus must not be captured
        vecs[9]  = mk(0,6'h00,0,1,6'h2A,32'h01234567,0,32'h0,        0,0,6'h05,32'h0,       0,1,32'hDEADBEEF,32'h0);
        vecs[10] = mk(0,6'h00,0,1,6'h2A,32'h01234567,0,32'hCAFEF00D, 0,1,6'h2A,32'h01234567,0,1,32'hDEADBEEF,32'h0);
        vecs[11] = mk(0,6'h00,0,1,6'h2A,32'h01234567,0,32'hCAFEF00D, 0,1,6'h2A,32'h01234567,0,1,32'hDEADBEEF,32'h0);
        vecs[12] = mk(0,6'h00,0,1,6'h2A,32'h01234567,0,32'hCAFEF00D, 0,0,6'h2A,32'h01234567,0,0,32'hDEADBEEF,32'h0);
        vecs[13] = mk(0,6'h00,0,0,6'h00,32'h01234567,0,32'h0,        0,0,6'h2A,32'h01234567,0,0,32'hDEADBEEF,32'h0);
        // D read, zero-wait: data sampled at the WAIT->DONE edge only
        vecs[14] = mk(0,6'h00,1,0,6'h3F,32'h01234567,0,32'h11111111, 0,0,6'h2A,32'h01234567,0,1,32'hDEADBEEF,32'h0);
        vecs[15] = mk(0,6'h00,1,0,6'h3F,32'h01234567,0,32'h22222222, 1,0,6'h3F,32'h01234567,0,1,32'hDEADBEEF,32'h0);
        vecs[16] = mk(0,6'h00,1,0,6'h3F,32'h01234567,0,32'h5A5A5A5A, 1,0,6'h3F,32'h01234567,0,1,32'hDEADBEEF,32'h0);
        vecs[17] = mk(0,6'h00,1,0,6'h3F,32'h01234567,0,32'h0,        0,0,6'h3F,32'h01234567,0,0,32'hDEADBEEF,32'h5A5A5A5A);
        vecs[18] = mk(0,6'h00,0,0,6'h00,32'h01234567,0,32'h0,        0,0,6'h3F,32'h01234567,0,0,32'hDEADBEEF,32'h5A5A5A5A);

        // reset state
        @(negedge CLK); #1;
        check("reset_outputs", {MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, I_READDATA, D_READDATA},
              128'd0);
        @(negedge CLK);
        RESET = 1'b1;

        for (int k = 0; k < 19; k++) begin
            @(negedge CLK);
            apply_vec(vecs[k], k);
        end

        // reset during WAIT of an I read, then the held request is re-granted
        @(negedge CLK);
        I_READ = 1'b1; I_ADDRESS = 6'h07; MEM_BUSYWAIT = 1'b1; MEM_READDATA = 32'h0;
        @(negedge CLK);
        @(negedge CLK); #1;
        check("wait_before_reset_mem_read", {127'd0, MEM_READ}, 128'd1);
        RESET = 1'b0;
        #1;
        check("reset_mid_wait", {MEM_READ, MEM_WRITE, MEM_ADDRESS, I_READDATA, D_READDATA, I_BUSYWAIT},
              {1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b1});
        @(negedge CLK);
        RESET = 1'b1; MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'h77770007;
        #1;
        cyc = 0;
        while (I_BUSYWAIT && cyc < 15) begin
            @(negedge CLK); #1;
            cyc++;
        end
        check("regrant_latency", cyc, 3);
        check("regrant_data", {96'd0, I_READDATA}, {96'd0, 32'h77770007});
        I_READ = 1'b0;

        // simultaneous I and D reads: D first, then I
        @(negedge CLK);
        I_READ = 1'b1; I_ADDRESS = 6'h01; D_READ = 1'b1; D_ADDRESS = 6'h10;
        MEM_READDATA = 32'hAAAA0001;
        d_done = -1; i_done = -1; cyc = 0;
        while (i_done < 0 && cyc < 20) begin
            @(negedge CLK); #1;
            cyc++;
            if (cyc == 1) check("tie_first_grant_addr", {122'd0, MEM_ADDRESS}, {122'd0, 6'h10});
            if (cyc == 5) check("tie_second_grant", {121'd0, MEM_READ, MEM_ADDRESS}, {121'd0, 1'b1, 6'h01});
            if (D_READ && !D_BUSYWAIT) begin
                d_done = cyc;
                check("loser_stalled_in_d_done", {127'd0, I_BUSYWAIT}, 128'd1);
                D_READ = 1'b0; MEM_READDATA = 32'hBBBB0002;
            end
            if (I_READ && !I_BUSYWAIT) begin
                i_done = cyc;
                I_READ = 1'b0;
            end
        end
        check("tie_d_done_cycle", d_done, 3);
        check("tie_i_done_cycle", i_done, 7);
        check("tie_d_data", {96'd0, D_READDATA}, {96'd0, 32'hAAAA0001});
        check("tie_i_data", {96'd0, I_READDATA}, {96'd0, 32'hBBBB0002});

        // request withdrawn after grant still completes and updates read data
        @(negedge CLK);
        I_READ = 1'b1; I_ADDRESS = 6'h09; MEM_READDATA = 32'h99990009;
        @(negedge CLK);
        I_READ = 1'b0;
        #1;
        check("withdrawn_strobe", {126'd0, MEM_READ, I_BUSYWAIT}, {126'd0, 1'b1, 1'b0});
        @(negedge CLK);
        @(negedge CLK); #1;
        check("withdrawn_data", {96'd0, I_READDATA}, {96'd0, 32'h99990009});

        // D finishes last, then a tie: round robin hands the port to I
        @(negedge CLK);
        D_READ = 1'b1; D_ADDRESS = 6'h11; MEM_READDATA = 32'h0;
        #1;
        cyc = 0;
        while (D_BUSYWAIT && cyc < 15) begin
            @(negedge CLK); #1;
            cyc++;
        end
        check("d_only_latency", cyc, 3);
        D_READ = 1'b0;
        @(negedge CLK);
        I_READ = 1'b1; I_ADDRESS = 6'h02; D_READ = 1'b1; D_ADDRESS = 6'h12;
        @(negedge CLK); #1;
`ifdef ARB_ROUND_ROBIN_EN
        check("tie_after_d_winner", {122'd0, MEM_ADDRESS}, {122'd0, 6'h02});
`else
        check("tie_after_d_winner", {122'd0, MEM_ADDRESS}, {122'd0, 6'h12});
`endif
        I_READ = 1'b0; D_READ = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
